// File: rtl/protected_access_controller.sv
// ---------------------------------------------------------------------------
// protected_access_controller
//
// Purpose:
//    Guards a small bank of registers behind a per-register permission table.
//    Each request carries a 4-bit key. The request is granted only when the
//    target index exists, the key matches the table entry for that index, and
//    the entry allows the requested operation. A granted access produces a
//    single one-hot enable pulse to the bank. Every accepted request, granted
//    or not, ends with a one-cycle response.
//
// Ports:
//    clk, reset          rising-edge clock, asynchronous active-high reset
//    req_valid/ready     request handshake (ready only while idle)
//    req_write           1 = write, 0 = read
//    req_addr            target register index
//    req_wdata           write data
//    req_key             requester permission key
//    cfg_valid           permission-table write strobe
//    cfg_addr            table entry to overwrite
//    cfg_key             new key for that entry
//    cfg_rd_allow        new read permission for that entry
//    cfg_wr_allow        new write permission for that entry
//    reg_write_enable    one-hot write strobe to the bank
//    reg_read_enable     one-hot read strobe to the bank
//    reg_wdata           shared write-data bus to the bank
//    reg_rdata           registered read bus driven by the bank
//    rsp_valid           one-cycle response strobe
//    rsp_error           response reports a denied access
//    rsp_rdata           data from the most recent granted read
// ---------------------------------------------------------------------------
module protected_access_controller #(
   parameter int WIDTH  = 8,
   parameter int NREGS  = 4,
   parameter int ADDR_W = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [WIDTH-1:0]  req_wdata,
   input  logic [3:0]        req_key,
   input  logic              cfg_valid,
   input  logic [ADDR_W-1:0] cfg_addr,
   input  logic [3:0]        cfg_key,
   input  logic              cfg_rd_allow,
   input  logic              cfg_wr_allow,
   output logic [NREGS-1:0]  reg_write_enable,
   output logic [NREGS-1:0]  reg_read_enable,
   output logic [WIDTH-1:0]  reg_wdata,
   input  logic [WIDTH-1:0]  reg_rdata,
   output logic              rsp_valid,
   output logic              rsp_error,
   output logic [WIDTH-1:0]  rsp_rdata
);

   localparam logic [2:0] IDLE    = 3'd0;
   localparam logic [2:0] CHECK   = 3'd1;
   localparam logic [2:0] ISSUE   = 3'd2;
   localparam logic [2:0] CAPTURE = 3'd3;
   localparam logic [2:0] RESP    = 3'd4;

   logic [2:0]        state_q;
   logic [2:0]        state_d;

   logic              reqWrite_q;
   logic [ADDR_W-1:0] reqAddr_q;
   logic [WIDTH-1:0]  reqWdata_q;
   logic [3:0]        reqKey_q;

   logic              rspError_q;
   logic [WIDTH-1:0]  rspRdata_q;

   logic [3:0]        tableKey_q [NREGS];
   logic [NREGS-1:0]  tableRd_q;
   logic [NREGS-1:0]  tableWr_q;

   logic              acceptReq;
   logic              entryHit;
   logic [3:0]        entryKey;
   logic              entryRd;
   logic              entryWr;
   logic              accessGrant;
   logic [NREGS-1:0]  addrOneHot;
   logic [NREGS-1:0]  cfgOneHot;

   // The block only listens to requests while idle; anything presented while
   // a transaction is in flight is simply not accepted.
   assign req_ready = (state_q == IDLE);
   assign acceptReq = req_valid && req_ready;

   // Decode the latched request index into a one-hot vector. An index at or
   // above NREGS decodes to all zeros, which also makes the table lookup miss.
   always_comb begin
      addrOneHot = '0;
      for (int i = 0; i < NREGS; i++) begin
         if (reqAddr_q == ADDR_W'(i)) begin
            addrOneHot[i] = 1'b1;
         end
      end
   end

   // Same decode for the configuration port so that an out-of-range cfg_addr
   // touches no entry at all.
   always_comb begin
      cfgOneHot = '0;
      for (int i = 0; i < NREGS; i++) begin
         if (cfg_addr == ADDR_W'(i)) begin
            cfgOneHot[i] = 1'b1;
         end
      end
   end

   // Fetch the permission entry for the latched request. The lookup is done
   // by scanning rather than indexing so that a too-large index never reads
   // past the table; entryHit doubles as the "index exists" test.
   always_comb begin
      entryHit = 1'b0;
      entryKey = 4'd0;
      entryRd  = 1'b0;
      entryWr  = 1'b0;
      for (int i = 0; i < NREGS; i++) begin
         if (addrOneHot[i]) begin
            entryHit = 1'b1;
            entryKey = tableKey_q[i];
            entryRd  = tableRd_q[i];
            entryWr  = tableWr_q[i];
         end
      end
   end

   // The grant is evaluated from the registered table, so a configuration
   // write landing on the same edge as the check still sees the old entry.
   assign accessGrant = entryHit
                     && (entryKey == reqKey_q)
                     && (reqWrite_q ? entryWr : entryRd);

   // Permission table. Reset clears every entry to key 0 with no rights, so
   // the block denies everything until software opens entries up.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NREGS; i++) begin
            tableKey_q[i] <= 4'd0;
         end
         tableRd_q <= '0;
         tableWr_q <= '0;
      end else if (cfg_valid) begin
         for (int i = 0; i < NREGS; i++) begin
            if (cfgOneHot[i]) begin
               tableKey_q[i] <= cfg_key;
               tableRd_q[i]  <= cfg_rd_allow;
               tableWr_q[i]  <= cfg_wr_allow;
            end
         end
      end
   end

   // Transaction sequencing. A denial skips straight to the response; a
   // granted write needs only the issue cycle; a granted read also waits one
   // cycle for the bank's registered read data.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (acceptReq) begin
               state_d = CHECK;
            end
         end
         CHECK: begin
            state_d = accessGrant ? ISSUE : RESP;
         end
         ISSUE: begin
            state_d = reqWrite_q ? RESP : CAPTURE;
         end
         CAPTURE: begin
            state_d = RESP;
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State register. The asynchronous reset drops any transaction in flight,
   // which also kills an enable pulse in the same instant.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Capture the request fields on acceptance. reqWdata_q drives the bank's
   // write bus directly, so it holds until the next accepted request.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         reqWrite_q <= 1'b0;
         reqAddr_q  <= '0;
         reqWdata_q <= '0;
         reqKey_q   <= 4'd0;
      end else if (acceptReq) begin
         reqWrite_q <= req_write;
         reqAddr_q  <= req_addr;
         reqWdata_q <= req_wdata;
         reqKey_q   <= req_key;
      end
   end

   // The error flag is decided at the check and cleared as the response
   // retires, so it is only ever high alongside rsp_valid.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rspError_q <= 1'b0;
      end else if (state_q == CHECK) begin
         rspError_q <= !accessGrant;
      end else if (state_q == RESP) begin
         rspError_q <= 1'b0;
      end
   end

   // Read data is taken from the bank only at the end of CAPTURE; writes and
   // denials never pass through CAPTURE, so they leave the old value alone.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rspRdata_q <= '0;
      end else if (state_q == CAPTURE) begin
         rspRdata_q <= reg_rdata;
      end
   end

   // Bank strobes exist only in ISSUE and only one direction is ever driven,
   // so the two vectors can never be nonzero together.
   always_comb begin
      reg_write_enable = '0;
      reg_read_enable  = '0;
      if (state_q == ISSUE) begin
         if (reqWrite_q) begin
            reg_write_enable = addrOneHot;
         end else begin
            reg_read_enable = addrOneHot;
         end
      end
   end

   assign reg_wdata = reqWdata_q;
   assign rsp_valid = (state_q == RESP);
   assign rsp_error = rspError_q;
   assign rsp_rdata = rspRdata_q;

endmodule

// File: tb/tb_protected_access_controller.sv
// ---------------------------------------------------------------------------
// tb_protected_access_controller
//
// Purpose:
//    Scoreboard bench for protected_access_controller. The stimulus side keeps
//    a plain reference model (permission table, register contents, last read
//    value) and pushes the expected response of every accepted request into
//    a queue. An independent monitor watches the DUT outputs, pops an entry
//    whenever rsp_valid appears, and compares error flag, read data, enable
//    pulses and latency. A simple register-bank model answers read strobes
//    with registered data and puts random noise on the bus otherwise.
// ---------------------------------------------------------------------------
module tb_protected_access_controller;

   localparam int WIDTH  = 8;
   localparam int NREGS  = 4;
   localparam int ADDR_W = 2;

   logic              clk;
   logic              reset;
   logic              req_valid;
   logic              req_ready;
   logic              req_write;
   logic [ADDR_W-1:0] req_addr;
   logic [WIDTH-1:0]  req_wdata;
   logic [3:0]        req_key;
   logic              cfg_valid;
   logic [ADDR_W-1:0] cfg_addr;
   logic [3:0]        cfg_key;
   logic              cfg_rd_allow;
   logic              cfg_wr_allow;
   logic [NREGS-1:0]  reg_write_enable;
   logic [NREGS-1:0]  reg_read_enable;
   logic [WIDTH-1:0]  reg_wdata;
   logic [WIDTH-1:0]  reg_rdata;
   logic              rsp_valid;
   logic              rsp_error;
   logic [WIDTH-1:0]  rsp_rdata;

   typedef struct {
      logic             err;
      logic [WIDTH-1:0] rdata;
      logic [NREGS-1:0] we;
      logic [NREGS-1:0] re;
      logic [WIDTH-1:0] wdata;
      int               lat;
      string            name;
   } expT;

   expT expQ[$];

   int testsRun    = 0;
   int testsFailed = 0;

   // Reference model state
   logic [3:0]       refKey [NREGS];
   logic             refRd  [NREGS];
   logic             refWr  [NREGS];
   logic [WIDTH-1:0] refMem [NREGS];
   logic [WIDTH-1:0] lastRd;

   // Monitor bookkeeping
   int               negCyc    = 0;
   int               acceptNeg = 0;
   int               enCycles  = 0;
   int               rspCount  = 0;
   logic [NREGS-1:0] seenWe    = '0;
   logic [NREGS-1:0] seenRe    = '0;

   // Bank model
   logic [WIDTH-1:0] bankMem [NREGS] = '{8'h11, 8'h22, 8'h33, 8'h44};
   logic [WIDTH-1:0] bankRdQ     = '0;
   logic             bankRdValid = 1'b0;
   logic [WIDTH-1:0] bankNoise   = '0;

   protected_access_controller #(
      .WIDTH (WIDTH),
      .NREGS (NREGS),
      .ADDR_W(ADDR_W)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .req_valid       (req_valid),
      .req_ready       (req_ready),
      .req_write       (req_write),
      .req_addr        (req_addr),
      .req_wdata       (req_wdata),
      .req_key         (req_key),
      .cfg_valid       (cfg_valid),
      .cfg_addr        (cfg_addr),
      .cfg_key         (cfg_key),
      .cfg_rd_allow    (cfg_rd_allow),
      .cfg_wr_allow    (cfg_wr_allow),
      .reg_write_enable(reg_write_enable),
      .reg_read_enable (reg_read_enable),
      .reg_wdata       (reg_wdata),
      .reg_rdata       (reg_rdata),
      .rsp_valid       (rsp_valid),
      .rsp_error       (rsp_error),
      .rsp_rdata       (rsp_rdata)
   );

   // Free-running clock, period 10
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Register bank: writes land on the strobed edge, reads return registered
   // data for one cycle, and the rest of the time the bus carries noise so a
   // capture in the wrong cycle shows up.
   always @(posedge clk) begin
      bankRdValid <= 1'b0;
      bankNoise   <= WIDTH'($urandom);
      for (int i = 0; i < NREGS; i++) begin
         if (reg_write_enable[i]) begin
            bankMem[i] <= reg_wdata;
         end
         if (reg_read_enable[i]) begin
            bankRdQ     <= bankMem[i];
            bankRdValid <= 1'b1;
         end
      end
   end

   assign reg_rdata = bankRdValid ? bankRdQ : bankNoise;

   // One comparison: counts it, and reports it if it does not hold
   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      testsRun++;
      if (act !== exp) begin
         testsFailed++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitor: samples on the falling edge, tracks acceptance time and enable
   // pulses, and scores every response against the head of the queue.
   always @(negedge clk) begin
      negCyc++;
      if (reset) begin
         seenWe   = '0;
         seenRe   = '0;
         enCycles = 0;
      end else begin
         if (req_valid && req_ready) begin
            acceptNeg = negCyc;
            seenWe    = '0;
            seenRe    = '0;
            enCycles  = 0;
         end
         if ((reg_write_enable != '0) || (reg_read_enable != '0)) begin
            enCycles++;
            seenWe |= reg_write_enable;
            seenRe |= reg_read_enable;
            checkOutput("enableExclusive",
                        32'((reg_write_enable != '0) && (reg_read_enable != '0)), 32'd0);
            if ((reg_write_enable != '0) && (expQ.size() > 0)) begin
               checkOutput({expQ[0].name, "_wdataBus"}, 32'(reg_wdata), 32'(expQ[0].wdata));
            end
         end
         if (rsp_valid) begin
            rspCount++;
            if (expQ.size() == 0) begin
               checkOutput("unexpectedRsp", 32'd1, 32'd0);
            end else begin
               expT e;
               e = expQ.pop_front();
               checkOutput({e.name, "_err"},     32'(rsp_error), 32'(e.err));
               checkOutput({e.name, "_rdata"},   32'(rsp_rdata), 32'(e.rdata));
               checkOutput({e.name, "_we"},      32'(seenWe),    32'(e.we));
               checkOutput({e.name, "_re"},      32'(seenRe),    32'(e.re));
               checkOutput({e.name, "_enPulse"}, 32'(enCycles),
                           ((e.we | e.re) != '0) ? 32'd1 : 32'd0);
               checkOutput({e.name, "_latency"}, 32'(negCyc - acceptNeg), 32'(e.lat + 1));
            end
            seenWe   = '0;
            seenRe   = '0;
            enCycles = 0;
         end
      end
   end

   // Clears the model the way a reset clears the block
   task automatic modelReset();
      for (int i = 0; i < NREGS; i++) begin
         refKey[i] = 4'd0;
         refRd[i]  = 1'b0;
         refWr[i]  = 1'b0;
      end
      lastRd = '0;
   endtask

   // Writes one permission entry; the model takes it once the edge has passed
   task automatic applyCfg(input logic [ADDR_W-1:0] a, input logic [3:0] k,
                           input logic rd, input logic wr);
      cfg_valid    = 1'b1;
      cfg_addr     = a;
      cfg_key      = k;
      cfg_rd_allow = rd;
      cfg_wr_allow = wr;
      @(posedge clk);
      refKey[a] = k;
      refRd[a]  = rd;
      refWr[a]  = wr;
      #1;
      cfg_valid = 1'b0;
   endtask

   // Issues one request. At the cycle it is accepted, the model decides the
   // outcome from the table rules and queues the response it must produce.
   // holdBusy keeps req_valid high with junk fields one cycle into the
   // transaction; revoke clears this entry during the check cycle.
   task automatic applyStimulus(input logic wr, input logic [ADDR_W-1:0] addr,
                                input logic [WIDTH-1:0] wd, input logic [3:0] key,
                                input bit holdBusy, input bit revoke, input string name);
      expT e;
      bit  grant;
      int  budget;
      req_write = wr;
      req_addr  = addr;
      req_wdata = wd;
      req_key   = key;
      req_valid = 1'b1;
      budget    = 0;
      forever begin
         @(negedge clk);
         if (req_ready) break;
         budget++;
         if (budget > 20) begin
            checkOutput({name, "_readyTimeout"}, 32'd0, 32'd1);
            req_valid = 1'b0;
            return;
         end
         @(posedge clk);
         #1;
      end
      grant = (int'(addr) < NREGS) && (key == refKey[addr])
              && (wr ? refWr[addr] : refRd[addr]);
      if (grant && !wr) lastRd = refMem[addr];
      if (grant && wr) refMem[addr] = wd;
      e.err   = !grant;
      e.we    = (grant && wr)  ? NREGS'(1 << addr) : '0;
      e.re    = (grant && !wr) ? NREGS'(1 << addr) : '0;
      e.rdata = lastRd;
      e.wdata = wd;
      e.lat   = !grant ? 1 : (wr ? 2 : 3);
      e.name  = name;
      expQ.push_back(e);
      @(posedge clk);
      #1;
      if (holdBusy) begin
         req_write = 1'($urandom);
         req_addr  = ADDR_W'($urandom);
         req_wdata = WIDTH'($urandom);
         req_key   = 4'($urandom);
      end
      if (revoke) begin
         cfg_valid    = 1'b1;
         cfg_addr     = addr;
         cfg_key      = 4'd0;
         cfg_rd_allow = 1'b0;
         cfg_wr_allow = 1'b0;
      end
      if (holdBusy || revoke) begin
         @(posedge clk);
         if (revoke) begin
            refKey[addr] = 4'd0;
            refRd[addr]  = 1'b0;
            refWr[addr]  = 1'b0;
         end
         #1;
         cfg_valid = 1'b0;
      end
      req_valid = 1'b0;
   endtask

   // Waits for every queued response to come out, within a cycle budget
   task automatic waitDrain(input string name);
      int budget;
      budget = 0;
      while ((expQ.size() != 0) && (budget < 20)) begin
         @(posedge clk);
         #1;
         budget++;
      end
      checkOutput({name, "_drain"}, 32'(expQ.size()), 32'd0);
   endtask

   // Main sequence: reset values, directed scenarios, random traffic, then
   // a reset that interrupts a write in its issue cycle.
   initial begin
      logic [WIDTH-1:0] savedMem;
      int               rspBefore;
      reset        = 1'b1;
      req_valid    = 1'b0;
      req_write    = 1'b0;
      req_addr     = '0;
      req_wdata    = '0;
      req_key      = 4'd0;
      cfg_valid    = 1'b0;
      cfg_addr     = '0;
      cfg_key      = 4'd0;
      cfg_rd_allow = 1'b0;
      cfg_wr_allow = 1'b0;
      refMem       = '{8'h11, 8'h22, 8'h33, 8'h44};
      modelReset();
      #1;
      checkOutput("rstReady",  32'(req_ready),        32'd1);
      checkOutput("rstWe",     32'(reg_write_enable), 32'd0);
      checkOutput("rstRe",     32'(reg_read_enable),  32'd0);
      checkOutput("rstValid",  32'(rsp_valid),        32'd0);
      checkOutput("rstError",  32'(rsp_error),        32'd0);
      checkOutput("rstRdata",  32'(rsp_rdata),        32'd0);
      checkOutput("rstWdata",  32'(reg_wdata),        32'd0);
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;

      // Table starts as deny-all
      applyStimulus(1'b0, 2'd1, 8'h00, 4'd0, 1'b0, 1'b0, "denyAfterReset");
      waitDrain("denyAfterReset");

      // Open entry 2, write then read it back
      applyCfg(2'd2, 4'd5, 1'b1, 1'b1);
      applyStimulus(1'b1, 2'd2, 8'hA5, 4'd5, 1'b0, 1'b0, "writeA5");
      applyStimulus(1'b0, 2'd2, 8'h00, 4'd5, 1'b0, 1'b0, "readA5");
      waitDrain("readA5");
      checkOutput("readA5_bankMem", 32'(bankMem[2]), 32'h0000_00A5);

      // Wrong key, then a write to a read-only entry
      applyStimulus(1'b0, 2'd2, 8'h00, 4'd6, 1'b0, 1'b0, "keyMismatch");
      applyCfg(2'd1, 4'd3, 1'b1, 1'b0);
      applyStimulus(1'b1, 2'd1, 8'h5A, 4'd3, 1'b0, 1'b0, "writeNoAllow");
      applyStimulus(1'b0, 2'd1, 8'h00, 4'd3, 1'b1, 1'b0, "readOnlyOk");

      // Revoke during the check cycle: old grant holds, next request denied
      applyStimulus(1'b0, 2'd2, 8'h00, 4'd5, 1'b0, 1'b1, "revokeOld");
      applyStimulus(1'b0, 2'd2, 8'h00, 4'd5, 1'b0, 1'b0, "revokeNew");
      waitDrain("directed");

      // Random traffic with small key space so grants and denials both occur
      for (int n = 0; n < 150; n++) begin
         if ($urandom_range(0, 2) == 0) begin
            applyCfg(ADDR_W'($urandom), 4'($urandom_range(0, 3)),
                     1'($urandom), 1'($urandom));
         end
         applyStimulus(1'($urandom), ADDR_W'($urandom), WIDTH'($urandom),
                       4'($urandom_range(0, 3)), 1'($urandom), 1'b0, "rand");
         repeat ($urandom_range(0, 2)) @(posedge clk);
         #1;
      end
      waitDrain("random");

      // Reset while a granted write is in its issue cycle
      applyCfg(2'd3, 4'd9, 1'b1, 1'b1);
      savedMem = refMem[3];
      applyStimulus(1'b1, 2'd3, 8'h5C, 4'd9, 1'b0, 1'b0, "rstIssue");
      @(posedge clk);
      #1;
      checkOutput("rstIssue_wePulse", 32'(reg_write_enable), 32'h8);
      rspBefore = rspCount;
      reset = 1'b1;
      #1;
      checkOutput("midRst_we",    32'(reg_write_enable), 32'd0);
      checkOutput("midRst_re",    32'(reg_read_enable),  32'd0);
      checkOutput("midRst_ready", 32'(req_ready),        32'd1);
      checkOutput("midRst_valid", 32'(rsp_valid),        32'd0);
      expQ.delete();
      refMem[3] = savedMem;
      modelReset();
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      checkOutput("midRst_noRsp",   32'(rspCount),   32'(rspBefore));
      checkOutput("midRst_rdata",   32'(rsp_rdata),  32'd0);
      checkOutput("midRst_noWrite", 32'(bankMem[3]), 32'(savedMem));

      // Table is deny-all again after the reset
      applyStimulus(1'b0, 2'd2, 8'h00, 4'd5, 1'b0, 1'b0, "denyAfterMidRst");
      waitDrain("final");

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

   // Guard against a run that never ends
   initial begin
      #500000;
      testsFailed++;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule

// File: doc/protected_access_controller.md
PROTECTED_ACCESS_CONTROLLER -- requirements
Module: protected_access_controller

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the data width of each protected register.
REQ-002 The block SHALL have parameter NREGS, default 4, giving the number of protected registers driven.
REQ-003 The block SHALL have parameter ADDR_W, default 2, giving the address width; NREGS <= 2**ADDR_W.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock, rising-edge active.
REQ-005 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 The block SHALL have port req_valid, input, 1 bit: an access request is present.
REQ-007 The block SHALL have port req_ready, output, 1 bit: the block accepts a request this cycle.
REQ-008 The block SHALL have port req_write, input, 1 bit: 1 requests a write, 0 requests a read.
REQ-009 The block SHALL have port req_addr, input, ADDR_W bits: the target register index.
REQ-010 The block SHALL have port req_wdata, input, WIDTH bits: the write data.
REQ-011 The block SHALL have port req_key, input, 4 bits: the requester's permission key.
REQ-012 The block SHALL have ports cfg_valid, cfg_addr[ADDR_W], cfg_key[4], cfg_rd_allow and cfg_wr_allow, all inputs, forming the permission-table write port.
REQ-013 The block SHALL have port reg_write_enable, output, NREGS bits: a one-hot write strobe to the register bank.
REQ-014 The block SHALL have port reg_read_enable, output, NREGS bits: a one-hot read strobe to the register bank.
REQ-015 The block SHALL have port reg_wdata, output, WIDTH bits: the shared write-data bus to the bank.
REQ-016 The block SHALL have port reg_rdata, input, WIDTH bits: the shared read bus, registered and tri-stated by the bank.
REQ-017 The block SHALL have ports rsp_valid (1 bit), rsp_error (1 bit) and rsp_rdata (WIDTH bits), all outputs, forming the response.

Function
REQ-018 The block SHALL hold a permission table with one entry per register: key[3:0], rd_allow, wr_allow.
REQ-019 When cfg_valid=1 at a rising edge, the block SHALL write the table entry at cfg_addr; the new value SHALL be visible from the next cycle; an access check in the same cycle SHALL use the old value.
REQ-020 The block SHALL implement an FSM with states IDLE, CHECK, ISSUE, CAPTURE and RESP.
REQ-021 req_ready SHALL be 1 only in IDLE; a request SHALL be accepted on a rising edge with req_valid=1 and req_ready=1, latching write, addr, wdata and key, and the FSM SHALL go to CHECK.
REQ-022 In CHECK, the access SHALL be granted iff addr < NREGS, key == table key[addr], and the allow bit for the operation is set; a grant SHALL go to ISSUE, a denial SHALL go to RESP with rsp_error=1.
REQ-023 In ISSUE, exactly one bit reg_write_enable[addr] or reg_read_enable[addr] SHALL be 1 for exactly one cycle; a write SHALL then go to RESP and a read SHALL go to CAPTURE.
REQ-024 In CAPTURE, all enables SHALL be 0; reg_rdata SHALL be sampled into rsp_rdata at the end of CAPTURE, and the FSM SHALL go to RESP.
REQ-025 In RESP, rsp_valid SHALL be 1 for exactly one cycle, and the FSM SHALL then return to IDLE.
REQ-026 Latency from the accepting edge to rsp_valid=1 SHALL be 3 edges for a granted read, 2 for a granted write, and 1 for a denial.
REQ-027 rsp_rdata SHALL hold its last captured value until the next granted read; writes and denials SHALL leave rsp_rdata unchanged.
REQ-028 reg_wdata SHALL equal the latched wdata from acceptance until the next acceptance.
REQ-029 All enables SHALL be 0 in every state except ISSUE; both enable vectors SHALL never be nonzero at the same time.
REQ-030 The block SHALL accept no new request while busy; req_valid outside IDLE SHALL be ignored.

Reset
REQ-031 When reset=1, the block SHALL asynchronously force state=IDLE; req_ready=1; enables=0; rsp_valid=0; rsp_error=0; rsp_rdata=0; reg_wdata=0; and all table entries to key=0, rd_allow=0, wr_allow=0 (deny all).
REQ-032 If reset occurs mid-transaction, the transaction SHALL be dropped, with no response and no further enable pulses.

Verification
REQ-033 Bench SHALL cover: after reset, read of addr 1 with key 0 -> no enables, rsp_valid with rsp_error=1 one edge after acceptance.
REQ-034 Bench SHALL cover: cfg entry 2 with key=5 and both allow bits set, write 0xA5 with key 5 -> reg_write_enable=4'b0100 for one cycle, rsp_valid with no error 2 edges after acceptance.
REQ-035 Bench SHALL cover: with the bank model holding 0xA5 at addr 2, read with key 5 -> reg_read_enable=4'b0100 for one cycle, rsp_rdata=0xA5 3 edges after acceptance.
REQ-036 Bench SHALL cover: key mismatch (key 6) or write to an entry with wr_allow=0 -> rsp_error=1, zero enables, and rsp_rdata unchanged.
REQ-037 Bench SHALL cover: cfg revoke of entry 2 in the same cycle as CHECK -> the old grant applies; the next request is denied.
REQ-038 Bench SHALL cover: reset asserted during ISSUE -> enables drop immediately, no rsp_valid, and req_ready=1.
